// File: rtl/sys_defs.sv
// Shared pipeline definitions: the fetch-to-buffer packet, the default
// instruction-buffer depth and the NOP encoding.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define NOP 32'h00000013

package sys_defs;

    localparam int unsigned IB_DEPTH_DEFAULT = 8;
    localparam logic [31:0] NOP_INST         = `NOP;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } IF_IB_PACKET;

endpackage

`endif

// File: rtl/inst_buffer_if.sv
// Fetch/dispatch-facing signal bundle of the instruction buffer.
interface inst_buffer_if
    import sys_defs::*;
#(
    parameter int unsigned IB_DEPTH = IB_DEPTH_DEFAULT,
    parameter int unsigned IB_IDX_W = $clog2(IB_DEPTH)
) ();

    IF_IB_PACKET         if_ib_packet;
    logic                ib_flush;
    logic                dp_ready;
    IF_IB_PACKET         ib_dp_packet;
    logic                ib_full;
    logic                ib_empty;
    logic [IB_IDX_W:0]   ib_count;
    logic                ib_overflow;

    modport master (
        output if_ib_packet, ib_flush, dp_ready,
        input  ib_dp_packet, ib_full, ib_empty, ib_count, ib_overflow
    );

    modport slave (
        input  if_ib_packet, ib_flush, dp_ready,
        output ib_dp_packet, ib_full, ib_empty, ib_count, ib_overflow
    );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and dispatch, flushed on redirect.
// Full/empty decode from the registered count only, so fetch may use them combinationally.
module inst_buffer
    import sys_defs::*;
#(
    parameter int unsigned IB_DEPTH = IB_DEPTH_DEFAULT,
    parameter int unsigned IB_IDX_W = $clog2(IB_DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    inst_buffer_if.slave ib
);

    localparam logic [IB_IDX_W:0]   DEPTH_CNT = (IB_IDX_W + 1)'(IB_DEPTH);
    localparam logic [IB_IDX_W-1:0] IDX_ONE   = IB_IDX_W'(1);
    localparam logic [IB_IDX_W:0]   CNT_ONE   = (IB_IDX_W + 1)'(1);

    IF_IB_PACKET         entries [IB_DEPTH];
    logic [IB_IDX_W-1:0] head;
    logic [IB_IDX_W-1:0] tail;
    logic [IB_IDX_W:0]   count;
    logic                overflow;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    IF_IB_PACKET         head_pkt;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign push  = ib.if_ib_packet.valid && !full && !ib.ib_flush;
    assign pop   = !empty && ib.dp_ready && !ib.ib_flush;

    // Stale slots are masked so the head reads as all zeros when empty.
    always_comb begin
        head_pkt = '0;
        if (!empty) begin
            head_pkt       = entries[head];
            head_pkt.valid = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < IB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (ib.if_ib_packet.valid && full && !ib.ib_flush) begin
                overflow <= 1'b1;
            end
            if (ib.ib_flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    entries[tail] <= ib.if_ib_packet;
                    tail          <= tail + IDX_ONE;
                end
                if (pop) begin
                    head <= head + IDX_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    assign ib.ib_dp_packet = head_pkt;
    assign ib.ib_full      = full;
    assign ib.ib_empty     = empty;
    assign ib.ib_count     = count;
    assign ib.ib_overflow  = overflow;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: vector table for fill/drain, hand sequences for the rest.
module tb_inst_buffer;
    import sys_defs::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inst_buffer_if #(.IB_DEPTH(8)) bus ();

    inst_buffer #(.IB_DEPTH(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .ib    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_pc;
        logic        in_flush;
        logic        in_ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [3:0]  exp_count;
        logic        exp_full;
        logic        exp_empty;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return {16'hA5A5, pc[15:0]};
    endfunction

    function automatic vec_t mk(logic v, logic [31:0] pc, logic fl, logic rdy,
                                logic ev, logic [31:0] epc, logic [3:0] ecnt,
                                logic ef, logic ee, logic eo);
        vec_t r;
        r.in_valid = v;  r.in_pc = pc;  r.in_flush = fl;  r.in_ready = rdy;
        r.exp_valid = ev; r.exp_pc = epc; r.exp_count = ecnt;
        r.exp_full = ef; r.exp_empty = ee; r.exp_ovf = eo;
        return r;
    endfunction

    task automatic drive(logic v, logic [31:0] pc, logic fl, logic rdy);
        bus.if_ib_packet.valid = v;
        bus.if_ib_packet.inst  = inst_of(pc);
        bus.if_ib_packet.pc    = pc;
        bus.if_ib_packet.npc   = pc + 32'd4;
        bus.ib_flush           = fl;
        bus.dp_ready           = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_state(string tag, logic ev, logic [31:0] epc, logic [3:0] ecnt,
                                logic ef, logic ee, logic eo);
        check({tag, ".valid"}, 32'(bus.ib_dp_packet.valid), 32'(ev));
        check({tag, ".pc"},    bus.ib_dp_packet.pc,   ev ? epc : 32'd0);
        check({tag, ".inst"},  bus.ib_dp_packet.inst, ev ? inst_of(epc) : 32'd0);
        check({tag, ".npc"},   bus.ib_dp_packet.npc,  ev ? epc + 32'd4 : 32'd0);
        check({tag, ".count"}, 32'(bus.ib_count),     32'(ecnt));
        check({tag, ".full"},  32'(bus.ib_full),      32'(ef));
        check({tag, ".empty"}, 32'(bus.ib_empty),     32'(ee));
        check({tag, ".ovf"},   32'(bus.ib_overflow),  32'(eo));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Fill with dp_ready low, then drain in order.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 32'(4 * i), 1'b0, 1'b0,
                             1'b1, 32'h0, 4'(i + 1), i == 7, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1,
                             i < 7, (i < 7) ? 32'(4 * (i + 1)) : 32'h0, 4'(7 - i),
                             1'b0, i == 7, 1'b0));

        // Reset held two cycles with valid traffic driven.
        rst_n = 1'b0;
        drive(1'b1, 32'h80, 1'b0, 1'b1);
        step();
        expect_state("rst0", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        expect_state("rst1", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_state("idle", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].in_valid, tbl[k].in_pc, tbl[k].in_flush, tbl[k].in_ready);
            step();
            expect_state($sformatf("vec%0d", k), tbl[k].exp_valid, tbl[k].exp_pc,
                         tbl[k].exp_count, tbl[k].exp_full, tbl[k].exp_empty, tbl[k].exp_ovf);
        end

        // Push-to-head latency is exactly one cycle.
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        #1;
        check("lat.same_cycle_valid", 32'(bus.ib_dp_packet.valid), 32'd0);
        step();
        expect_state("lat.next", 1'b1, 32'h200, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        expect_state("lat.pop", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Concurrent push/pop at count 3 across the pointer wrap.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h300 + 4 * i), 1'b0, 1'b0);
            step();
            expect_state($sformatf("wrap.fill%0d", i), 1'b1, 32'h300, 4'(i + 1),
                         1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'(32'h30C + 4 * k), 1'b0, 1'b1);
            step();
            expect_state($sformatf("wrap.pp%0d", k), 1'b1, 32'(32'h300 + 4 * (k + 1)), 4'd3,
                         1'b0, 1'b0, 1'b0);
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            step();
            expect_state($sformatf("wrap.drain%0d", j), j < 2,
                         (j < 2) ? 32'(32'h354 + 4 * j) : 32'h0, 4'(2 - j),
                         1'b0, j == 2, 1'b0);
        end

        // Push while full is dropped even with dp_ready; overflow is sticky.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        expect_state("ovf.full", 1'b1, 32'h0, 4'd8, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        step();
        expect_state("ovf.drop", 1'b1, 32'h4, 4'd7, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        step();
        expect_state("ovf.refill", 1'b1, 32'h4, 4'd8, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            step();
            expect_state($sformatf("ovf.drain%0d", j), j < 7,
                         (j < 6) ? 32'(32'h8 + 4 * j) : ((j == 6) ? 32'h44 : 32'h0),
                         4'(7 - j), 1'b0, j == 7, 1'b1);
        end

        // Flush discards same-cycle push and pop; next-cycle push is accepted.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(32'h500 + 4 * i), 1'b0, 1'b0);
            step();
        end
        expect_state("fl.pre", 1'b1, 32'h500, 4'd5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h514, 1'b1, 1'b1);
        step();
        expect_state("fl.flush", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        expect_state("fl.push", 1'b1, 32'h100, 4'd1, 1'b0, 1'b0, 1'b1);

        // Reset mid-traffic wins and clears the sticky overflow.
        rst_n = 1'b0;
        drive(1'b1, 32'h600, 1'b0, 1'b1);
        step();
        expect_state("rst.mid", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_state("rst.after", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
